// File: rtl/c_port_arbiter_pkg.sv
// Shared types and constants for the C_* command-port arbiter.
package c_port_arbiter_pkg;

    localparam int ARB_TIMEOUT = 1023;

    typedef logic [1:0] Arb_State;

    localparam Arb_State IDLE  = 2'd0;
    localparam Arb_State ISSUE = 2'd1;
    localparam Arb_State WAIT  = 2'd2;
    localparam Arb_State RESP  = 2'd3;

    // Next round-robin start position; explicit compare so non-power-of-two N works.
    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/c_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(N_REQ);

    int pos;

    // Scan from the farthest offset down so the closest match to rr_ptr wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (req[IDX_W'(pos)]) begin
                any = 1'b1;
                idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/c_port_arbiter.sv
// Round-robin sharing of the single bridge C_* port with one outstanding transaction
// and a watchdog that turns a missing bridge response into an error response.
module c_port_arbiter
    import c_port_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_r_wb,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data_w,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      C_in_valid,
    output logic                      C_r_wb,
    output logic [ADDR_W-1:0]         C_addr,
    output logic [DATA_W-1:0]         C_data_w,
    input  logic                      C_out_valid,
    input  logic [DATA_W-1:0]         C_data_r
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // Widths follow the module parameters, so the command type lives here.
    typedef struct packed {
        logic              r_wb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } C_Cmd;

    Arb_State         state;
    logic [IDX_W-1:0] rr_ptr;
    logic [WD_W-1:0]  wdog;
    logic [WD_W-1:0]  wd_inc;
    C_Cmd             cmd;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    assign wd_inc   = (wdog == WD_LAST) ? wdog : wdog + 1'b1;
    assign C_r_wb   = cmd.r_wb;
    assign C_addr   = cmd.addr;
    assign C_data_w = cmd.data;

    // Pulses default low; each state raises only what it owns for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            wdog       <= '0;
            grant_id   <= '0;
            cmd        <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            C_in_valid <= 1'b0;
        end else begin
            req_ready  <= '0;
            rsp_valid  <= '0;
            C_in_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id   <= pick_idx;
                        cmd.r_wb   <= req_r_wb[pick_idx];
                        cmd.addr   <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        cmd.data   <= req_data_w[pick_idx*DATA_W +: DATA_W];
                        req_ready  <= N_REQ'(1) << pick_idx;
                        C_in_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wd_inc;
                    // A response in the timeout cycle still counts as a real response.
                    if (C_out_valid) begin
                        rsp_data  <= cmd.r_wb ? C_data_r : '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= N_REQ'(1) << grant_id;
                        state     <= RESP;
                    end else if (wd_inc == WD_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= N_REQ'(1) << grant_id;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= IDX_W'(rr_next(int'(grant_id), N_REQ));
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c_port_arbiter.sv
// Directed bench for c_port_arbiter: 2 requesters, TIMEOUT = 8, hand-computed expectations.
module tb_c_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_r_wb;
    logic [15:0] req_addr;
    logic [63:0] req_data_w;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        busy;
    logic [0:0]  grant_id;
    logic        C_in_valid;
    logic        C_r_wb;
    logic [7:0]  C_addr;
    logic [31:0] C_data_w;
    logic        C_out_valid;
    logic [31:0] C_data_r;

    int n_checks = 0;
    int n_errors = 0;

    c_port_arbiter #(
        .N_REQ(2), .ADDR_W(8), .DATA_W(32), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_r_wb(req_r_wb), .req_addr(req_addr),
        .req_data_w(req_data_w), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy), .grant_id(grant_id),
        .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transaction from a single requester; delay = extra WAIT cycles
    // before the bridge answers (0 = first WAIT cycle).
    task automatic applyStimulus(input string tag, input int idx, input logic r_wb,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input int delay, input logic [31:0] rdata,
                                 input logic [31:0] exp_data);
        logic [1:0] oh;
        oh = 2'b01 << idx;
        req_valid = oh;
        req_r_wb[idx] = r_wb;
        req_addr[idx*8 +: 8] = addr;
        req_data_w[idx*32 +: 32] = wdata;
        tick();
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(oh));
        checkOutput({tag, "_c_in_valid"}, 64'(C_in_valid), 64'd1);
        checkOutput({tag, "_c_addr"}, 64'(C_addr), 64'(addr));
        checkOutput({tag, "_c_r_wb"}, 64'(C_r_wb), 64'(r_wb));
        checkOutput({tag, "_c_data_w"}, 64'(C_data_w), 64'(wdata));
        checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'(idx));
        req_valid = 2'b00;
        tick();
        checkOutput({tag, "_wait_no_cmd"}, 64'(C_in_valid), 64'd0);
        repeat (delay) tick();
        C_out_valid = 1'b1;
        C_data_r = rdata;
        tick();
        C_out_valid = 1'b0;
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
        checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_data));
        checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        tick();
        checkOutput({tag, "_idle_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got hang expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int cycles;
        logic [1:0] oh;
        rst_n = 1'b0;
        req_valid = '0;
        req_r_wb = '0;
        req_addr = '0;
        req_data_w = '0;
        C_out_valid = 1'b0;
        C_data_r = '0;
        tick();
        tick();
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_outs", {req_ready, rsp_valid, C_in_valid, rsp_err, grant_id}, 64'd0);
        checkOutput("reset_cmd", {C_r_wb, C_addr, C_data_w}, 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_no_req", 64'(busy), 64'd0);

        applyStimulus("single_read", 0, 1'b1, 8'h12, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF);
        checkOutput("read_data_held", 64'(rsp_data), 64'hDEADBEEF);
        applyStimulus("write", 1, 1'b0, 8'h20, 32'h0000_00FF, 0, 32'h1234, 32'h0);

        // Both requesters keep asking; the granted one drops for a cycle after req_ready.
        req_r_wb = 2'b11;
        req_addr = {8'hB1, 8'hA0};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            oh = 2'b01 << (i % 2);
            tick();
            checkOutput("fair_grant", 64'(grant_id), 64'(i % 2));
            checkOutput("fair_ready", 64'(req_ready), 64'(oh));
            checkOutput("fair_addr", 64'(C_addr), (i % 2 == 0) ? 64'hA0 : 64'hB1);
            req_valid = req_valid & ~oh;
            tick();
            C_out_valid = 1'b1;
            C_data_r = 32'h100 + i;
            tick();
            C_out_valid = 1'b0;
            checkOutput("fair_rsp", 64'(rsp_valid), 64'(oh));
            checkOutput("fair_data", 64'(rsp_data), 64'(32'h100 + i));
            checkOutput("fair_resp_no_issue", 64'(C_in_valid), 64'd0);
            if (i < 5) req_valid = req_valid | oh;
            else req_valid = 2'b00;
            tick();
            checkOutput("fair_idle", 64'(busy), 64'd0);
        end

        // Watchdog: bridge silent, error response 8 cycles after the ISSUE cycle.
        req_r_wb = 2'b01;
        req_addr = {8'h00, 8'h33};
        req_valid = 2'b01;
        tick();
        checkOutput("to_issue", 64'(C_in_valid), 64'd1);
        req_valid = 2'b00;
        cycles = 0;
        for (int k = 0; k < 20 && rsp_valid == 2'b00; k++) begin
            tick();
            cycles++;
        end
        checkOutput("to_latency", 64'(cycles), 64'd8);
        checkOutput("to_rsp_valid", 64'(rsp_valid), 64'b01);
        checkOutput("to_rsp_err", 64'(rsp_err), 64'd1);
        checkOutput("to_rsp_data", 64'(rsp_data), 64'd0);
        tick();
        C_out_valid = 1'b1;
        C_data_r = 32'h5555;
        tick();
        C_out_valid = 1'b0;
        checkOutput("stray_rsp", 64'(rsp_valid), 64'd0);
        checkOutput("stray_busy", 64'(busy), 64'd0);
        checkOutput("stray_err_held", 64'(rsp_err), 64'd1);

        // Reset in WAIT: requester 1 is granted (rr_ptr = 1 after the timeout).
        req_r_wb = 2'b00;
        req_addr = {8'h44, 8'h00};
        req_data_w = {32'h77, 32'h0};
        req_valid = 2'b10;
        tick();
        checkOutput("rst_pre_grant", 64'(grant_id), 64'd1);
        req_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_outs", {req_ready, rsp_valid, C_in_valid, rsp_err, grant_id}, 64'd0);
        checkOutput("rst_cmd", {C_r_wb, C_addr, C_data_w}, 64'd0);
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        C_out_valid = 1'b1;
        C_data_r = 32'h9999;
        tick();
        C_out_valid = 1'b0;
        checkOutput("rst_late_rsp", 64'(rsp_valid), 64'd0);
        req_r_wb = 2'b11;
        req_addr = {8'h66, 8'h65};
        req_valid = 2'b11;
        tick();
        checkOutput("rst_first_grant", 64'(grant_id), 64'd0);
        checkOutput("rst_first_ready", 64'(req_ready), 64'b01);
        req_valid = 2'b00;
        tick();
        C_out_valid = 1'b1;
        C_data_r = 32'h0BAD_CAFE;
        tick();
        C_out_valid = 1'b0;
        checkOutput("rst_next_rsp", 64'(rsp_valid), 64'b01);
        checkOutput("rst_next_data", 64'(rsp_data), 64'h0BADCAFE);
        tick();

        // Bridge answers in the 7th WAIT cycle, the same cycle the watchdog would fire.
        applyStimulus("collide", 1, 1'b1, 8'h5A, 32'h0, 6, 32'hCAFEF00D, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/c_port_arbiter.md
Name: c_port_arbiter

Overview:
- Shares the single farm-to-bridge C_* command port (C_addr / C_data_w / C_r_wb / C_in_valid → C_out_valid / C_data_r) between N_REQ requesters, for example the farm FSM and a background DRAM scrubber or logger.
- Round-robin grant with exactly one outstanding bridge transaction.
- Routes the bridge response back to the granted requester.
- A watchdog turns a missing response into an error response.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, width of the C_addr word address
- DATA_W, 32, width of C_data_w / C_data_r
- TIMEOUT, 1023, WAIT cycles without C_out_valid before an error response (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  N_REQ  request pending per requester; held high until the matching req_ready
- req_r_wb  in  N_REQ  1 = read, 0 = write, per requester
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data_w  in  N_REQ*DATA_W  packed write data
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
- rsp_valid  out  N_REQ  one-cycle response pulse to the granted requester
- rsp_err  out  1  qualifies rsp_valid; 1 = watchdog timeout
- rsp_data  out  DATA_W  read data; 0 for writes and for errors
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester
- C_in_valid  out  1  one-cycle command pulse to the bridge
- C_r_wb  out  1  command direction
- C_addr  out  ADDR_W  command address
- C_data_w  out  DATA_W  command write data
- C_out_valid  in  1  one-cycle completion pulse from the bridge
- C_data_r  in  DATA_W  read data, valid with C_out_valid

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE, rr_ptr = 0, watchdog = 0, grant_id = 0.
  - All outputs are registered and go to 0.
  - An in-flight transaction is abandoned silently: no rsp_valid, and a late C_out_valid is treated as stray.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick g = first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Latch g, req_r_wb[g], req_addr[g] and req_data_w[g] into registers, then go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready[g] = 1 and C_in_valid = 1.
  - C_r_wb / C_addr / C_data_w carry the latched fields.
  - Watchdog is cleared. Next state is WAIT.
- C_addr / C_data_w / C_r_wb hold their latched values from ISSUE until the next ISSUE; they are 0 only after reset.
- WAIT:
  - The watchdog increments every cycle.
  - On C_out_valid: capture rsp_data = (latched r_wb ? C_data_r : 0), rsp_err = 0, go to RESP.
  - Else, if the watchdog reaches TIMEOUT - 1: rsp_data = 0, rsp_err = 1, go to RESP.
  - If C_out_valid arrives in the same cycle as the timeout, the response wins (rsp_err = 0).
- RESP (exactly 1 cycle):
  - rsp_valid[g] = 1 with rsp_err and rsp_data valid.
  - rr_ptr = (g + 1) mod N_REQ. Next state is IDLE.
- rsp_err and rsp_data hold their values until the next RESP.
- Stray responses: C_out_valid seen in IDLE, ISSUE or RESP is ignored; no output changes.
- Requester contract:
  - req_valid and its fields stay stable until req_ready is seen.
  - req_valid is deasserted in the cycle after req_ready.
  - Requests are sampled only in IDLE; a req_valid dropped before grant is simply never served.
- Latency:
  - req_valid seen in IDLE at cycle t gives req_ready and C_in_valid at t+1.
  - C_out_valid at cycle u gives rsp_valid at u+1.
  - Minimum turnaround per transaction is 4 cycles (bridge answering in the first WAIT cycle).
- Fairness: with every requester continuously requesting, grants rotate 0,1,…,N_REQ-1,0; no requester waits more than N_REQ-1 transactions.
- Widths:
  - Watchdog counter is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT - 1.
  - rr_ptr wraps modulo N_REQ (explicit compare, not power-of-two wrap).

Decomposition:
- usertype package:
  - typedef enum Arb_State {IDLE, ISSUE, WAIT, RESP}.
  - packed struct C_Cmd {r_wb, addr[ADDR_W], data[DATA_W]} used for the latched command.
  - localparam ARB_TIMEOUT default.
- Sub-module rr_pick: purely combinational round-robin selector with inputs req vector and rr_ptr, outputs any and idx.
- The FSM, watchdog and response registers stay in c_port_arbiter.

Test Plan:
1. Single read: req_valid = 01, addr 8'h12 → req_ready[0] and C_in_valid pulse at t+1 with C_addr = 8'h12, C_r_wb = 1. Bridge returns 32'hDEADBEEF after 3 cycles → rsp_valid = 01, rsp_data = 32'hDEADBEEF, rsp_err = 0.
2. Write: requester 1 writes 32'h0000_00FF to 8'h20 → C_data_w = 32'hFF, C_r_wb = 0. C_out_valid with C_data_r = 32'h1234 → rsp_valid = 10, rsp_data = 0.
3. Fairness: both requesters held continuously for 6 transactions, rr_ptr = 0 → grant order 0,1,0,1,0,1, and each pair is issued only after the previous RESP.
4. Timeout: TIMEOUT = 8, bridge never answers → rsp_valid 8 cycles after ISSUE with rsp_err = 1, rsp_data = 0. A late C_out_valid in IDLE is ignored.
5. Reset mid-WAIT: rst_n low for 1 cycle while in WAIT → busy = 0 and all outputs 0 at the next cycle. A subsequent C_out_valid produces no rsp_valid, and the next request grants requester 0 first.
6. Timeout collision: C_out_valid coincides with watchdog = TIMEOUT - 1 → rsp_err = 0 and rsp_data = C_data_r.
